// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp32_pkg
// Description : Shared definitions for the binary32 adder: format widths,
//               canonical special encodings, the unpacked-operand struct and
//               an unpack helper that applies denormals-are-zero.
// Revision    : 1.0 - initial release
// ============================================================================
package fp32_pkg;

    localparam int WIDTH_NUMBER = 32;
    localparam int EXP_W        = 8;
    localparam int FRAC_W       = 23;
    localparam int BIAS         = 127;
    localparam int SIG_W        = FRAC_W + 1;   // significand with hidden bit

    localparam logic [WIDTH_NUMBER-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [WIDTH_NUMBER-1:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fp_unpacked_t;

    // Splits a binary32 word. The sign may be flipped (subtraction of B).
    // Exponent 0 yields a zero significand, so denormals behave as signed zero.
    function automatic fp_unpacked_t unpack(input logic [WIDTH_NUMBER-1:0] value,
                                            input logic                    flip_sign);
        fp_unpacked_t u;
        u.sign = value[WIDTH_NUMBER-1] ^ flip_sign;
        u.exp  = value[WIDTH_NUMBER-2:FRAC_W];
        u.sig  = (u.exp == '0) ? '0 : {1'b1, value[FRAC_W-1:0]};
        return u;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_lzc.sv
`default_nettype none
// ============================================================================
// Module      : fp32_lzc
// Description : 24-bit leading-zero counter used to normalise the significand
//               sum after cancellation. An all-zero input reports 24.
// Ports       : value [23:0] in  - vector to scan, bit 23 is the MSB
//               count [4:0]  out - number of zeros above the first set bit
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_lzc (
    input  logic [23:0] value,
    output logic [4:0]  count
);

    // Scanning upward, the last set bit seen is the most significant one.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (value[i]) begin
                count = 5'(23 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ieee_adder.sv
`default_nettype none
// ============================================================================
// Module      : ieee_adder
// Description : Two-stage pipelined binary32 adder/subtractor, round to
//               nearest even, denormal inputs read as zero, tiny results
//               flushed to signed zero. New operands accepted every cycle.
// Ports       : clock_in    in  - rising-edge clock
//               reset_n     in  - asynchronous active-low reset
//               add_sub_bit in  - 0 = A + B, 1 = A - B
//               inputA/B    in  - binary32 operands
//               outputC     out - registered binary32 result, 2-edge latency
// Revision    : 1.0 - initial release
// ============================================================================
module ieee_adder
    import fp32_pkg::*;
(
    input  logic                    clock_in,
    input  logic                    reset_n,
    input  logic                    add_sub_bit,
    input  logic [WIDTH_NUMBER-1:0] inputA,
    input  logic [WIDTH_NUMBER-1:0] inputB,
    output logic [WIDTH_NUMBER-1:0] outputC
);

    // ------------------------------------------------------------ stage 1
    fp_unpacked_t op_a, op_b, op_large, op_small;
    logic         b_larger;
    logic         nan_a, nan_b, inf_a, inf_b;
    logic         special;
    logic [31:0]  special_val;
    logic [7:0]   exp_diff;
    logic [4:0]   shift_amt;
    logic [49:0]  small_wide;
    logic [26:0]  small_aligned;

    assign op_a = unpack(inputA, 1'b0);
    assign op_b = unpack(inputB, add_sub_bit);

    // Exponent then significand; equal exponents fall through to the fraction.
    assign b_larger = {op_b.exp, op_b.sig} > {op_a.exp, op_a.sig};
    assign op_large = b_larger ? op_b : op_a;
    assign op_small = b_larger ? op_a : op_b;

    assign nan_a = (&inputA[30:23]) && (|inputA[22:0]);
    assign nan_b = (&inputB[30:23]) && (|inputB[22:0]);
    assign inf_a = (&inputA[30:23]) && !(|inputA[22:0]);
    assign inf_b = (&inputB[30:23]) && !(|inputB[22:0]);

    always_comb begin
        special     = 1'b1;
        special_val = QNAN;
        if (nan_a || nan_b || (inf_a && inf_b && (op_a.sign != op_b.sign))) begin
            special_val = QNAN;
        end else if (inf_a) begin
            special_val = {op_a.sign, POS_INF[30:0]};
        end else if (inf_b) begin
            special_val = {op_b.sign, POS_INF[30:0]};
        end else begin
            special = 1'b0;
        end
    end

    // Alignment: the small significand is placed above 26 spare bits and
    // shifted; the top 26 bits keep significand+guard+round, the rest
    // collapse into sticky. A shift of 26 pushes everything into sticky.
    assign exp_diff      = op_large.exp - op_small.exp;
    assign shift_amt     = (exp_diff > 8'd26) ? 5'd26 : exp_diff[4:0];
    assign small_wide    = {op_small.sig, 26'b0} >> shift_amt;
    assign small_aligned = {small_wide[49:24], |small_wide[23:0]};

    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [26:0] s1_big;
    logic [26:0] s1_small;
    logic        s1_sub;
    logic        s1_special;
    logic [31:0] s1_special_val;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            s1_sign        <= 1'b0;
            s1_exp         <= '0;
            s1_big         <= '0;
            s1_small       <= '0;
            s1_sub         <= 1'b0;
            s1_special     <= 1'b0;
            s1_special_val <= '0;
        end else begin
            s1_sign        <= op_large.sign;
            s1_exp         <= op_large.exp;
            s1_big         <= {op_large.sig, 3'b000};
            s1_small       <= small_aligned;
            s1_sub         <= op_large.sign ^ op_small.sign;
            s1_special     <= special;
            s1_special_val <= special_val;
        end
    end

    // ------------------------------------------------------------ stage 2
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic [26:0]        norm;
    logic signed [9:0]  exp_norm;
    logic signed [9:0]  exp_final;
    logic               round_up;
    logic [24:0]        rounded;
    logic [22:0]        frac_final;
    logic [31:0]        result;

    // Operands are ordered by magnitude, so the difference never goes negative.
    assign sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                        : ({1'b0, s1_big} + {1'b0, s1_small});

    // Only the integer part is scanned: heavy cancellation happens only for
    // exponent gaps of 0 or 1, where nothing below the guard bit is set, so a
    // count of 24 still lands the guard bit on the hidden-bit position.
    fp32_lzc u_lzc (
        .value (sum[26:3]),
        .count (lz)
    );

    always_comb begin
        norm       = '0;
        exp_norm   = '0;
        round_up   = 1'b0;
        rounded    = '0;
        exp_final  = '0;
        frac_final = '0;
        result     = '0;

        if (sum[27]) begin
            norm     = {sum[27:2], sum[1] | sum[0]};
            exp_norm = $signed({2'b00, s1_exp}) + 10'sd1;
        end else begin
            norm     = sum[26:0] << lz;
            exp_norm = $signed({2'b00, s1_exp}) - $signed({5'b00000, lz});
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded  = {1'b0, norm[26:3]} + {24'b0, round_up};

        // A rounding carry leaves 1.000..0, one binade up.
        if (rounded[24]) begin
            frac_final = rounded[23:1];
            exp_final  = exp_norm + 10'sd1;
        end else begin
            frac_final = rounded[22:0];
            exp_final  = exp_norm;
        end

        if (s1_special) begin
            result = s1_special_val;
        end else if (sum == '0) begin
            // Unlike-signed cancellation is +0; like-signed zeros keep the sign.
            result = {s1_sub ? 1'b0 : s1_sign, 31'b0};
        end else if (exp_final >= 10'sd255) begin
            result = {s1_sign, POS_INF[30:0]};
        end else if (exp_final <= 10'sd0) begin
            result = {s1_sign, 31'b0};
        end else begin
            result = {s1_sign, exp_final[7:0], frac_final};
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            outputC <= '0;
        end else begin
            outputC <= result;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ieee_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ieee_adder
// Description : Directed self-checking bench for ieee_adder: arithmetic,
//               alignment, zeros, rounding, specials, back-to-back pipeline
//               ordering and asynchronous reset mid-stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ieee_adder;

    logic        clock_in    = 1'b0;
    logic        reset_n     = 1'b0;
    logic        add_sub_bit = 1'b0;
    logic [31:0] inputA      = '0;
    logic [31:0] inputB      = '0;
    logic [31:0] outputC;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] pa [8] = '{32'h3FC00000, 32'h41000000, 32'h3F800000, 32'hC0400000,
                            32'h3F000000, 32'h3F800001, 32'h7F7FFFFF, 32'h41000000};
    logic [31:0] pb [8] = '{32'h3F000000, 32'h3FC00000, 32'h33800001, 32'hC0400000,
                            32'h40F00000, 32'h33800000, 32'h7F7FFFFF, 32'hC0E00000};
    logic [31:0] pe [8] = '{32'h40000000, 32'h41180000, 32'h3F800001, 32'hC0C00000,
                            32'h41000000, 32'h3F800002, 32'h7F800000, 32'h3F800000};

    ieee_adder dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .add_sub_bit (add_sub_bit),
        .inputA      (inputA),
        .inputB      (inputB),
        .outputC     (outputC)
    );

    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one operand pair and check it two rising edges later.
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic [31:0] exp);
        inputA      = a;
        inputB      = b;
        add_sub_bit = op;
        repeat (2) @(posedge clock_in);
        #1;
        check(tag, outputC, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check("reset_low", outputC, 32'h00000000);
        @(posedge clock_in);
        #1;
        check("reset_held", outputC, 32'h00000000);
        reset_n = 1'b1;

        // basic add / sub
        run("add_1p5_0p5",  32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000);
        run("add_swapped",  32'h3F000000, 32'h3FC00000, 1'b0, 32'h40000000);
        run("add_neg_b",    32'h3FC00000, 32'hBF000000, 1'b0, 32'h3F800000);
        run("add_neg_neg",  32'hC0400000, 32'hC0400000, 1'b0, 32'hC0C00000);
        run("sub_2_1",      32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000);
        // alignment / normalisation
        run("align_8_1p5",  32'h41000000, 32'h3FC00000, 1'b0, 32'h41180000);
        run("align_carry",  32'h3F000000, 32'h40F00000, 1'b0, 32'h41000000);
        run("norm_8m7",     32'h41000000, 32'hC0E00000, 1'b0, 32'h3F800000);
        // zeros and cancellation
        run("zero_pp",      32'h00000000, 32'h00000000, 1'b0, 32'h00000000);
        run("zero_nn",      32'h80000000, 32'h80000000, 1'b0, 32'h80000000);
        run("zero_pn",      32'h00000000, 32'h80000000, 1'b0, 32'h00000000);
        run("cancel_add",   32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000);
        run("cancel_sub",   32'h40A00000, 32'h40A00000, 1'b1, 32'h00000000);
        // rounding
        run("round_tie_ev", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000);
        run("round_above",  32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001);
        run("round_tie_od", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002);
        // specials
        run("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
        run("inf_minus_inf",32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000);
        run("inf_sub_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000);
        run("nan_in",       32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000);
        run("ninf_finite",  32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000);
        run("daz",          32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000);
        run("ftz",          32'h80C00001, 32'h00800000, 1'b0, 32'h80000000);

        // back-to-back: result of pair i appears after the edge following its sampling edge
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                inputA      = pa[i];
                inputB      = pb[i];
                add_sub_bit = 1'b0;
            end
            @(posedge clock_in);
            #1;
            if (i >= 1) begin
                check($sformatf("pipe%0d", i - 1), outputC, pe[i - 1]);
            end
        end

        // asynchronous reset in the middle of a stream
        inputA = pa[0];
        inputB = pb[0];
        @(posedge clock_in);
        #1;
        inputA = pa[1];
        inputB = pb[1];
        @(posedge clock_in);
        #1;
        check("pre_reset", outputC, pe[0]);
        inputA = pa[2];
        inputB = pb[2];
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_async", outputC, 32'h00000000);
        @(posedge clock_in);
        #1;
        check("reset_hold1", outputC, 32'h00000000);
        #2;
        reset_n = 1'b1;
        @(posedge clock_in);
        #1;
        check("post_reset1", outputC, 32'h00000000);
        @(posedge clock_in);
        #1;
        check("post_reset2", outputC, pe[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ieee_adder.md
Name: ieee_adder

Overview:
- IEEE-754 binary32 floating-point adder/subtractor with a pipelined, registered result.
- Computes outputC = inputA + inputB when add_sub_bit=0, or inputA - inputB when add_sub_bit=1.
- Serves as the arithmetic core for FP datapaths.
- Accepts a new operand pair every clock; no handshake.

Parameters:
- None; the format is fixed at binary32: 1 sign, 8 exponent bits (bias 127), 23 fraction bits.

Ports:
- clock_in  input  1  sole clock; all flops update on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- add_sub_bit  input  1  0 = add, 1 = subtract (sign of B inverted before the add).
- inputA  input  32  operand A, binary32.
- inputB  input  32  operand B, binary32.
- outputC  output  32  result, binary32, registered.

Behaviour:
- Reset: reset_n low asynchronously clears all pipeline registers; outputC = 32'h00000000 while reset_n is low and until the first valid result leaves the pipe.
- Reset mid-operation discards all in-flight results.
- Latency: exactly 2 rising edges. Inputs sampled at edge N appear on outputC after edge N+1.
- Throughput 1/cycle. Back-to-back operands never interfere.
- Stage 1 (align):
  - Unpack both operands; effective sign of B = signB XOR add_sub_bit.
  - Swap so the larger magnitude is first (compare exponent then fraction).
  - Restore the hidden 1 for normals.
  - Right-shift the smaller significand by the exponent difference, collecting guard, round and sticky bits. A shift of 26 or more leaves only sticky.
- Stage 2 (add/normalise/round), result registered into outputC:
  - Add or subtract the significands per the effective signs.
  - Normalise: on carry-out, shift right 1 and increment exponent; otherwise use a leading-zero count to left-shift and decrement exponent.
  - Round to nearest, ties to even. A rounding carry renormalises.
- Sign rules:
  - Result sign = sign of the larger-magnitude operand.
  - Exact cancellation (x - x) gives +0.
  - (-0) + (-0) = -0; (+0) + (-0) = +0.
- Denormals: inputs with exponent 0 are treated as signed zero (DAZ). Results with exponent below 1 flush to signed zero (FTZ).
- Overflow: a result exponent of 255 or more gives signed infinity (exp = FF, fraction 0).
- Specials (exponent FF on an input):
  - Any NaN input, or +inf + -inf (after effective sign), gives canonical NaN 32'h7FC00000.
  - inf + finite = that inf.
- Equal exponents with differing fractions must still choose the correct larger operand.
- No exceptions or flags are output.

Decomposition:
- Shared package fp32_pkg:
  - WIDTH_NUMBER = 32, EXP_W = 8, FRAC_W = 23, BIAS = 127.
  - Constants QNAN = 32'h7FC00000, POS_INF = 32'h7F800000.
  - Unpacked-operand struct typedef {sign, exp, sig}.
- One natural sub-module: fp32_lzc (24-bit leading-zero counter) used in the normalise step.
- Everything else stays inline.

Test Plan:
- Add 3FC00000 (1.5) + 3F000000 (0.5) -> 40000000; swapped operands -> 40000000; 3FC00000 + BF000000 -> 3F800000; C0400000 + C0400000 -> C0C00000. Each is checked 2 edges after applying.
- Align/normalise: 41000000 (8) + 3FC00000 (1.5) -> 41180000; 3F000000 + 40F00000 (7.5) -> 41000000; 41000000 + C0E00000 (8 - 7) -> 3F800000.
- Zeros and cancellation:
  - 00000000 + 00000000 -> 00000000.
  - 80000000 + 80000000 -> 80000000.
  - 3F800000 + BF800000 -> 00000000.
  - add_sub_bit=1 with 40A00000 - 40A00000 -> 00000000.
- Rounding: 3F800000 + 33800000 (tie) -> 3F800000; 3F800000 + 33800001 -> 3F800001; 3F800001 + 33800000 (tie, odd) -> 3F800002.
- Specials:
  - 7F7FFFFF + 7F7FFFFF -> 7F800000.
  - 7F800000 + FF800000 -> 7FC00000.
  - 00400000 (denormal) + 3F800000 -> 3F800000.
  - 80C00001 + 00800000 -> 80000000 (FTZ).
- Pipeline/reset: apply a new pair every cycle for 8 cycles and check each result lands exactly 2 edges later in order. Assert reset_n low mid-stream: outputC goes to 00000000 immediately and remains there until fresh results emerge.
